ic_number_encoder: RTL and testbench

IC_NUMBER_ENCODER -- requirements
Module: ic_number_encoder

---
 rtl/ic_number_encoder.sv | 158 +++++++++++++++
 tb/tb_ic_number_encoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ic_number_encoder.sv
// ic_number_encoder
//   Collects decimal keypad digits into an unsigned binary IC number, commits
//   it on enter and flags whether the committed part number is in the list of
//   supported 74xx parts.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digit_valid  in   one-cycle strobe, digit carries a keypad digit
//   digit[3:0]   in   keypad digit, legal 0-9
//   enter        in   one-cycle strobe, commit the current entry
//   clear        in   one-cycle strobe, abort/erase the entry
//   digit_ready  out  a digit strobe will be accepted
//   icNumber     out  committed IC number (32-bit unsigned)
//   number_valid out  icNumber holds a committed entry
//   supported    out  committed icNumber is a supported part
//   digit_count  out  digits in the current entry
//   error        out  entry is in the error state
//   err_code     out  00 none, 01 illegal digit, 10 overflow, 11 empty enter
module ic_number_encoder #(
    parameter int MAX_DIGITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        clear,
    output logic        digit_ready,
    output logic [31:0] icNumber,
    output logic        number_valid,
    output logic        supported,
    output logic [3:0]  digit_count,
    output logic        error,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] ic_q, ic_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nv_q, nv_d;
    logic        sup_q, sup_d;
    logic        err_q, err_d;
    logic        rdy_q, rdy_d;
    logic [1:0]  code_q, code_d;

    function automatic logic is_supported(input logic [31:0] v);
        case (v)
            32'd7400, 32'd7403, 32'd7404, 32'd7405, 32'd7408, 32'd7409,
            32'd7410, 32'd7411, 32'd7412, 32'd7414, 32'd7420, 32'd7421,
            32'd7427, 32'd7430, 32'd7432, 32'd7486, 32'd74132:
                is_supported = 1'b1;
            default:
                is_supported = 1'b0;
        endcase
    endfunction

    // acc*10 + d built from shifts: acc*8 + acc*2 + d
    function automatic logic [31:0] mul10_add(input logic [31:0] a, input logic [3:0] d);
        mul10_add = (a << 3) + (a << 1) + {28'd0, d};
    endfunction

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ic_d    = ic_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        sup_d   = sup_q;
        code_d  = code_q;

        // Priority: clear > enter > digit; lower strobes in the same cycle are dropped.
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ic_d    = '0;
            cnt_d   = '0;
            nv_d    = 1'b0;
            sup_d   = 1'b0;
            code_d  = 2'b00;
        end else if (enter) begin
            if (state_q == ENTRY) begin
                state_d = DONE;
                ic_d    = acc_q;
                nv_d    = 1'b1;
                sup_d   = is_supported(acc_q);
            end else if (state_q == IDLE) begin
                state_d = ERR;
                code_d  = 2'b11;
            end
        end else if (digit_valid && state_q != ERR) begin
            if (digit > 4'd9) begin
                state_d = ERR;
                code_d  = 2'b01;
            end else if (state_q == DONE) begin
                // New entry after a commit; icNumber holds until the next enter.
                state_d = ENTRY;
                acc_d   = {28'd0, digit};
                cnt_d   = 4'd1;
                nv_d    = 1'b0;
                sup_d   = 1'b0;
            end else if (cnt_q >= MAX_CNT) begin
                state_d = ERR;
                code_d  = 2'b10;
            end else begin
                state_d = ENTRY;
                acc_d   = mul10_add(acc_q, digit);
                cnt_d   = cnt_q + 4'd1;
            end
        end

        err_d = (state_d == ERR);
        rdy_d = (state_d != ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ic_q    <= '0;
            cnt_q   <= '0;
            nv_q    <= 1'b0;
            sup_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ic_q    <= ic_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            sup_q   <= sup_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            code_q  <= code_d;
        end
    end

    assign digit_ready  = rdy_q;
    assign icNumber     = ic_q;
    assign number_valid = nv_q;
    assign supported    = sup_q;
    assign digit_count  = cnt_q;
    assign error        = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_ic_number_encoder.sv
// Testbench for ic_number_encoder: directed scenarios followed by random
// strobes compared against a digit-list reference model.
module tb_ic_number_encoder;

    localparam int MAXD = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        enter;
    logic        clear;
    logic        digit_ready;
    logic [31:0] icNumber;
    logic        number_valid;
    logic        supported;
    logic [3:0]  digit_count;
    logic        error;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    ic_number_encoder #(.MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .clear(clear), .digit_ready(digit_ready),
        .icNumber(icNumber), .number_valid(number_valid), .supported(supported),
        .digit_count(digit_count), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: the entry is a list of digits; modes are plain flags.
    int unsigned m_digits[$];
    bit          m_err, m_done, m_nv, m_sup;
    int unsigned m_code;
    longint unsigned m_ic;
    int unsigned sup_list[17] = '{7400, 7403, 7404, 7405, 7408, 7409, 7410, 7411,
                                  7412, 7414, 7420, 7421, 7427, 7430, 7432, 7486, 74132};

    function automatic longint unsigned value_of(input int unsigned ds[$]);
        longint unsigned v = 0;
        foreach (ds[i]) v = v * 10 + ds[i];
        return v;
    endfunction

    function automatic bit in_list(input longint unsigned v);
        foreach (sup_list[i]) if (sup_list[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_digits.delete();
        m_err = 0; m_done = 0; m_nv = 0; m_sup = 0; m_code = 0; m_ic = 0;
    endtask

    task automatic m_step(input bit dv, input int unsigned d, input bit en, input bit cl);
        if (cl) begin
            m_reset();
        end else if (en) begin
            if (!m_err && !m_done) begin
                if (m_digits.size() == 0) begin
                    m_err = 1; m_code = 3;
                end else begin
                    m_done = 1; m_ic = value_of(m_digits); m_nv = 1; m_sup = in_list(m_ic);
                end
            end
        end else if (dv && !m_err) begin
            if (d > 9) begin
                m_err = 1; m_code = 1;
            end else if (m_done) begin
                m_digits.delete(); m_digits.push_back(d);
                m_done = 0; m_nv = 0; m_sup = 0;
            end else if (m_digits.size() == MAXD) begin
                m_err = 1; m_code = 2;
            end else begin
                m_digits.push_back(d);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ic"},    icNumber,     32'(m_ic));
        chk({tag, ".nv"},    number_valid, 32'(m_nv));
        chk({tag, ".sup"},   supported,    32'(m_sup));
        chk({tag, ".cnt"},   digit_count,  32'(m_digits.size()));
        chk({tag, ".err"},   error,        32'(m_err));
        chk({tag, ".code"},  err_code,     32'(m_code));
        chk({tag, ".rdy"},   digit_ready,  32'(!m_err));
    endtask

    // One clock with the given strobes; leaves time at posedge+1.
    task automatic cyc(input bit dv, input logic [3:0] d, input bit en, input bit cl);
        digit_valid = dv; digit = d; enter = en; clear = cl;
        @(posedge clk);
        #1;
        if (rst_n) m_step(dv, int'(d), en, cl);
        digit_valid = 0; enter = 0; clear = 0;
    endtask

    task automatic key_in(input int unsigned v);
        string s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) cyc(1, 4'(s[i] - "0"), 0, 0);
    endtask

    initial begin
        int unsigned probe[6] = '{7400, 7432, 7486, 7401, 74320, 7499};
        rst_n = 0; digit_valid = 0; digit = 0; enter = 0; clear = 0;
        m_reset();
        #12;
        chk("rst.ic", icNumber, 0);
        chk("rst.nv", number_valid, 0);
        chk("rst.sup", supported, 0);
        chk("rst.cnt", digit_count, 0);
        chk("rst.err", error, 0);
        chk("rst.code", err_code, 0);
        chk("rst.rdy", digit_ready, 1);
        cyc(1, 4'd5, 1, 0);
        chk("rst.strobe_cnt", digit_count, 0);
        @(negedge clk) rst_n = 1;

        key_in(74132); cyc(0, 0, 1, 0);
        chk("p74132.ic", icNumber, 74132);
        chk("p74132.nv", number_valid, 1);
        chk("p74132.sup", supported, 1);
        chk("p74132.cnt", digit_count, 5);

        cyc(0, 0, 0, 1); key_in(7499); cyc(0, 0, 1, 0);
        chk("p7499.ic", icNumber, 7499);
        chk("p7499.nv", number_valid, 1);
        chk("p7499.sup", supported, 0);
        cyc(1, 4'd7, 0, 0);
        chk("restart.nv", number_valid, 0);
        chk("restart.cnt", digit_count, 1);
        chk("restart.ic", icNumber, 7499);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 4'd1, 0, 0);
        chk("ovf.err", error, 1);
        chk("ovf.code", err_code, 2);
        chk("ovf.rdy", digit_ready, 0);
        chk("ovf.cnt", digit_count, 6);
        cyc(0, 0, 1, 0);
        chk_model("ovf_enter");
        chk("ovf_enter.code", err_code, 2);
        cyc(0, 0, 0, 1);
        chk("clr.cnt", digit_count, 0);
        chk("clr.err", error, 0);
        chk("clr.code", err_code, 0);
        chk("clr.rdy", digit_ready, 1);
        chk("clr.ic", icNumber, 0);

        cyc(1, 4'hA, 0, 0);
        chk("illegal.err", error, 1);
        chk("illegal.code", err_code, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 1, 0);
        chk("empty.err", error, 1);
        chk("empty.code", err_code, 3);

        cyc(0, 0, 0, 1); key_in(740); cyc(0, 0, 1, 1);
        chk("clrwin.nv", number_valid, 0);
        chk("clrwin.ic", icNumber, 0);
        chk("clrwin.cnt", digit_count, 0);
        chk("clrwin.rdy", digit_ready, 1);
        cyc(1, 4'd3, 0, 1);
        chk("clrdig.cnt", digit_count, 0);

        key_in(74);
        #2 rst_n = 0;
        #1;
        m_reset();
        chk("arst.cnt", digit_count, 0);
        chk("arst.ic", icNumber, 0);
        chk("arst.rdy", digit_ready, 1);
        #1 rst_n = 1;
        key_in(8); cyc(0, 0, 1, 0);
        chk("p8.ic", icNumber, 8);
        chk("p8.sup", supported, 0);

        foreach (probe[i]) begin
            cyc(0, 0, 0, 1); key_in(probe[i]); cyc(0, 0, 1, 0);
            chk($sformatf("probe%0d.sup", probe[i]), supported, 32'(in_list(probe[i])));
            chk($sformatf("probe%0d.ic", probe[i]), icNumber, probe[i]);
        end

        cyc(0, 0, 0, 1);
        for (int n = 0; n < 400; n++) begin
            bit cl_r, en_r, dv_r;
            logic [3:0] d_r;
            cl_r = ($urandom_range(0, 19) == 0);
            en_r = ($urandom_range(0, 5) == 0);
            dv_r = ($urandom_range(0, 1) == 1);
            d_r  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cyc(dv_r, d_r, en_r, cl_r);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
